// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vend_pkg
// Description : Shared types and helpers for the vending controller
//               (state encoding, credit width helper, default coin mask).
// Revision    : 1.0 - initial release
// ============================================================================
package vend_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_COLLECT = 4'b0010,
        ST_VEND    = 4'b0100,
        ST_PAYOUT  = 4'b1000
    } vend_state_e;

    localparam logic [7:0] C_DEFAULT_COIN_MASK = 8'b0010_0110;

    // Wide enough for the largest credit+coin sum: (PRICE-1) + (2**COIN_W-1).
    function automatic int credit_width(input int price, input int coin_w);
        return $clog2(price + 2**coin_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vend_payout_reg.sv
`default_nettype none
// ============================================================================
// Module      : vend_payout_reg
// Description : Change/refund holding register with valid/ready output.
//               Loaded by the controller FSM, reports completion back.
// Revision    : 1.0 - initial release
// ============================================================================
module vend_payout_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_check_rdy,
    output logic [WIDTH-1:0] o_check,
    output logic             o_check_vld,
    output logic             o_done
);

    logic [WIDTH-1:0] r_check;
    logic             r_vld;

    // Value stays frozen until accepted, then returns to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_check <= '0;
            r_vld   <= 1'b0;
        end else if (i_load) begin
            r_check <= i_load_val;
            r_vld   <= 1'b1;
        end else if (r_vld && i_check_rdy) begin
            r_check <= '0;
            r_vld   <= 1'b0;
        end
    end

    assign o_check     = r_check;
    assign o_check_vld = r_vld;
    assign o_done      = r_vld && i_check_rdy;

endmodule
`default_nettype wire

// File: rtl/vend_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vend_ctrl
// Description : Coin-operated vending controller: credit accumulation, vend
//               pulse, change/refund payout. Optional inactivity auto-refund
//               enabled by defining VEND_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int                     PRICE       = 5,
    parameter int                     COIN_W      = 3,
    parameter logic [2**COIN_W-1:0]   COIN_MASK   = (2**COIN_W)'(C_DEFAULT_COIN_MASK),
    parameter int                     TIMEOUT_CYC = 255,
    localparam int                    CREDIT_W    = credit_width(PRICE, COIN_W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [COIN_W-1:0]   m_in,
    input  logic                m_in_vld,
    output logic                m_in_rdy,
    input  logic                cancel,
    output logic                qout,
    output logic [CREDIT_W-1:0] check,
    output logic                check_vld,
    input  logic                check_rdy,
    output logic                reject,
    output logic [CREDIT_W-1:0] credit
);

    localparam logic [CREDIT_W-1:0] c_price = CREDIT_W'(PRICE);

    vend_state_e          r_state;
    vend_state_e          w_state_nxt;
    logic [CREDIT_W-1:0]  r_credit;
    logic [CREDIT_W-1:0]  w_credit_nxt;
    logic [CREDIT_W-1:0]  r_change;
    logic [CREDIT_W-1:0]  w_change_nxt;
    logic                 r_reject;
    logic                 w_coin_acc;
    logic                 w_coin_legal;
    logic [CREDIT_W-1:0]  w_sum;
    logic                 w_load;
    logic [CREDIT_W-1:0]  w_load_val;
    logic                 w_done;
    logic                 w_timeout;

    assign m_in_rdy     = (r_state == ST_IDLE) || (r_state == ST_COLLECT);
    assign w_coin_acc   = m_in_vld && m_in_rdy;
    assign w_coin_legal = w_coin_acc && (m_in != '0) && COIN_MASK[m_in];
    assign w_sum        = r_credit + CREDIT_W'(m_in);

`ifdef VEND_TIMEOUT_EN
    localparam int c_tmo_w = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [c_tmo_w-1:0] r_tmo_cnt;

    assign w_timeout = (r_state == ST_COLLECT) && !w_coin_legal &&
                       (r_tmo_cnt == c_tmo_w'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if ((r_state != ST_COLLECT) || w_coin_legal || w_timeout) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_credit <= '0;
            r_change <= '0;
            r_reject <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_credit <= w_credit_nxt;
            r_change <= w_change_nxt;
            r_reject <= w_coin_acc && !w_coin_legal;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_change_nxt = r_change;
        w_load       = 1'b0;
        w_load_val   = r_change;
        unique case (r_state)
            ST_IDLE, ST_COLLECT: begin
                // Abort wins over vend: a coin reaching PRICE is refunded too.
                if ((r_state == ST_COLLECT) && (cancel || w_timeout)) begin
                    w_load       = 1'b1;
                    w_load_val   = w_coin_legal ? w_sum : r_credit;
                    w_credit_nxt = '0;
                    w_state_nxt  = ST_PAYOUT;
                end else if (w_coin_legal) begin
                    if (w_sum >= c_price) begin
                        w_change_nxt = w_sum - c_price;
                        w_credit_nxt = '0;
                        w_state_nxt  = ST_VEND;
                    end else begin
                        w_credit_nxt = w_sum;
                        w_state_nxt  = ST_COLLECT;
                    end
                end
            end
            ST_VEND: begin
                w_change_nxt = '0;
                if (r_change != '0) begin
                    w_load      = 1'b1;
                    w_load_val  = r_change;
                    w_state_nxt = ST_PAYOUT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PAYOUT: begin
                if (w_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    vend_payout_reg #(
        .WIDTH (CREDIT_W)
    ) u_payout (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_load_val  (w_load_val),
        .i_check_rdy (check_rdy),
        .o_check     (check),
        .o_check_vld (check_vld),
        .o_done      (w_done)
    );

    assign qout   = (r_state == ST_VEND);
    assign reject = r_reject;
    assign credit = r_credit;

endmodule
`default_nettype wire
